// File: rtl/vga_sync_gen_if.sv
// Output bundle of the VGA timing generator: sync strobes, blanking and pixel position.
interface vga_sync_gen_if;
  logic       hsync;
  logic       vsync;
  logic       video_on;
  logic [9:0] pixel_x;
  logic [9:0] pixel_y;
  logic       pix_tick;
  logic       frame_start;

  modport master (
    output hsync, vsync, video_on, pixel_x, pixel_y, pix_tick, frame_start
  );

  modport slave (
    input  hsync, vsync, video_on, pixel_x, pixel_y, pix_tick, frame_start
  );
endinterface

// File: rtl/vga_sync_gen.sv
// Free-running VGA timing generator: clk prescaler, h/v pixel counters and
// registered sync/blanking decode, all outputs launched from flops.
module vga_sync_gen #(
  parameter int DIV    = 4,
  parameter int H_VIS  = 640,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_VIS  = 480,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33
) (
  input  logic            clk,
  input  logic            rst,
  vga_sync_gen_if.master  vga_o
);

  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int PW    = $clog2(DIV);

  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);
  localparam logic [9:0] H_LAST = 10'(H_TOT - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOT - 1);
  localparam logic [9:0] H_VEND = 10'(H_VIS);
  localparam logic [9:0] V_VEND = 10'(V_VIS);
  localparam logic [9:0] HS_BEG = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS_END = 10'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_BEG = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS_END = 10'(V_VIS + V_FP + V_SYNC - 1);

  logic          run_q, run_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          pix_tick_q, pix_tick_d;
  logic [9:0]    h_cnt_q, h_cnt_d;
  logic [9:0]    v_cnt_q, v_cnt_d;
  logic          started_q, started_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          video_on_q, video_on_d;
  logic [9:0]    pixel_x_q, pixel_x_d;
  logic [9:0]    pixel_y_q, pixel_y_d;
  logic          frame_start_q, frame_start_d;

  always_comb begin
    run_d         = 1'b1;
    presc_d       = presc_q;
    h_cnt_d       = h_cnt_q;
    v_cnt_d       = v_cnt_q;
    started_d     = started_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    video_on_d    = video_on_q;
    pixel_x_d     = pixel_x_q;
    pixel_y_d     = pixel_y_q;
    frame_start_d = 1'b0;

    // The first edge after reset release only arms the prescaler, so the
    // first tick lands on edge DIV and is high while the prescaler is DIV-1.
    if (run_q) begin
      presc_d = (presc_q == PRE_LAST) ? '0 : presc_q + 1'b1;
    end
    pix_tick_d = run_q && (presc_d == PRE_LAST);

    // Outputs show the pixel the counters held during the tick; the
    // counters move on to the next pixel on the same edge.
    if (pix_tick_q) begin
      pixel_x_d     = h_cnt_q;
      pixel_y_d     = v_cnt_q;
      hsync_d       = !((h_cnt_q >= HS_BEG) && (h_cnt_q <= HS_END));
      vsync_d       = !((v_cnt_q >= VS_BEG) && (v_cnt_q <= VS_END));
      video_on_d    = (h_cnt_q < H_VEND) && (v_cnt_q < V_VEND);
      frame_start_d = started_q && (h_cnt_q == '0) && (v_cnt_q == '0);
      started_d     = 1'b1;
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = '0;
        v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 10'd1;
      end else begin
        h_cnt_d = h_cnt_q + 10'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_q         <= 1'b0;
      presc_q       <= '0;
      pix_tick_q    <= 1'b0;
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      started_q     <= 1'b0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      video_on_q    <= 1'b0;
      pixel_x_q     <= '0;
      pixel_y_q     <= '0;
      frame_start_q <= 1'b0;
    end else begin
      run_q         <= run_d;
      presc_q       <= presc_d;
      pix_tick_q    <= pix_tick_d;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      started_q     <= started_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      video_on_q    <= video_on_d;
      pixel_x_q     <= pixel_x_d;
      pixel_y_q     <= pixel_y_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign vga_o.hsync       = hsync_q;
  assign vga_o.vsync       = vsync_q;
  assign vga_o.video_on    = video_on_q;
  assign vga_o.pixel_x     = pixel_x_q;
  assign vga_o.pixel_y     = pixel_y_q;
  assign vga_o.pix_tick    = pix_tick_q;
  assign vga_o.frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench: default 640x480 timing (DIV 4 and 2) plus a tiny 16x12
// raster (DIV 3) for whole-frame and wrap behaviour.
module tb_vga_sync_gen;

  logic clk = 1'b0;
  logic rst_a, rst_b, rst_s;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   rel    = 0;
  int   n;

  always #5 clk = ~clk;

  vga_sync_gen_if ifa ();
  vga_sync_gen_if ifb ();
  vga_sync_gen_if ifs ();

  vga_sync_gen #(.DIV(4)) dut_a (.clk(clk), .rst(rst_a), .vga_o(ifa));
  vga_sync_gen #(.DIV(2)) dut_b (.clk(clk), .rst(rst_b), .vga_o(ifb));
  vga_sync_gen #(
    .DIV(3), .H_VIS(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_VIS(6), .V_FP(2), .V_SYNC(2), .V_BP(2)
  ) dut_s (.clk(clk), .rst(rst_s), .vga_o(ifs));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Edge counter and event recorders, all sampled 1 time unit after posedge.
  int a_fall[$], a_rise[$], a_vcum[$];
  int b_fall[$], b_rise[$];
  int s_fs_t[$], s_vcum[$], s_vs_fall[$], s_vs_rise[$];
  int a_vid = 0, a_fs = 0, s_fs_hi = 0, s_vrise = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    logic a_hs_p, b_hs_p, s_vs_p, s_vo_p;
    a_hs_p = 1'b1; b_hs_p = 1'b1; s_vs_p = 1'b1; s_vo_p = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (ifa.video_on) a_vid++;
      if (ifa.frame_start) a_fs++;
      if (a_hs_p && !ifa.hsync) begin a_fall.push_back(cyc); a_vcum.push_back(a_vid); end
      if (!a_hs_p && ifa.hsync) a_rise.push_back(cyc);
      a_hs_p = ifa.hsync;
      if (b_hs_p && !ifb.hsync) b_fall.push_back(cyc);
      if (!b_hs_p && ifb.hsync) b_rise.push_back(cyc);
      b_hs_p = ifb.hsync;
      if (!s_vo_p && ifs.video_on) s_vrise++;
      s_vo_p = ifs.video_on;
      if (ifs.frame_start) begin s_fs_hi++; s_fs_t.push_back(cyc); s_vcum.push_back(s_vrise); end
      if (s_vs_p && !ifs.vsync) s_vs_fall.push_back(cyc);
      if (!s_vs_p && ifs.vsync) s_vs_rise.push_back(cyc);
      s_vs_p = ifs.vsync;
    end
  end

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; rst_s = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_a_outs", 32'({ifa.hsync, ifa.vsync, ifa.video_on, ifa.pix_tick, ifa.frame_start,
                           ifa.pixel_x, ifa.pixel_y}), 32'({5'b11000, 20'd0}));
    chk("rst_s_outs", 32'({ifs.hsync, ifs.vsync, ifs.video_on, ifs.pix_tick, ifs.frame_start,
                           ifs.pixel_x, ifs.pixel_y}), 32'({5'b11000, 20'd0}));

    // Release between edges and walk the first eight edges.
    rst_a = 1'b0; rst_b = 1'b0; rst_s = 1'b0;
    rel = cyc;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("a_tick_e%0d", k), 32'(ifa.pix_tick), 32'(k % 4 == 0));
      chk($sformatf("a_vid_e%0d", k), 32'(ifa.video_on), 32'(k >= 5));
      chk($sformatf("b_tick_e%0d", k), 32'(ifb.pix_tick), 32'(k % 2 == 0));
      chk($sformatf("b_px_e%0d", k), 32'(ifb.pixel_x), 32'((k >= 3) ? (k - 3) / 2 : 0));
      chk($sformatf("s_tick_e%0d", k), 32'(ifs.pix_tick), 32'(k % 3 == 0));
      if (k >= 5) chk($sformatf("a_xy_e%0d", k), 32'({ifa.pixel_x, ifa.pixel_y}), 32'd0);
    end

    // Tiny raster wrap from (15,11) to (0,0).
    n = 0;
    while (!(ifs.pixel_x == 10'd15 && ifs.pixel_y == 10'd11) && n < 2000) begin
      @(posedge clk); #1; n++;
    end
    chk("s_reach_last", 32'(n < 2000), 32'd1);
    n = 0;
    while (!ifs.frame_start && n < 100) begin
      @(posedge clk); #1; n++;
    end
    chk("s_wrap_seen", 32'(n < 100), 32'd1);
    chk("s_wrap_xy", 32'({ifs.pixel_x, ifs.pixel_y}), 32'd0);
    chk("s_wrap_syncs", 32'({ifs.hsync, ifs.vsync, ifs.video_on}), 32'b111);
    chk("s_first_fs_time", 32'(cyc - rel), 32'd580);
    @(posedge clk); #1;
    chk("s_fs_width", 32'(ifs.frame_start), 32'd0);

    // Whole-frame measurements on the tiny raster (48 clk lines, 576 clk frames).
    while (cyc < rel + 1800) @(posedge clk);
    @(negedge clk);
    chk("s_fs_count", 32'(s_fs_t.size()), 32'd3);
    chk("s_fs_hi_clks", 32'(s_fs_hi), 32'd3);
    chk("s_frame_per0", 32'(s_fs_t[1] - s_fs_t[0]), 32'd576);
    chk("s_frame_per1", 32'(s_fs_t[2] - s_fs_t[1]), 32'd576);
    chk("s_vs_low", 32'(s_vs_rise[0] - s_vs_fall[0]), 32'd96);
    chk("s_vs_period", 32'(s_vs_fall[1] - s_vs_fall[0]), 32'd576);
    chk("s_vis_lines", 32'(s_vcum[1] - s_vcum[0]), 32'd6);

    // Async reset of the default raster while inside the hsync pulse.
    n = 0;
    while (!(ifa.pixel_x == 10'd700 && ifa.pixel_y == 10'd1) && n < 10000) begin
      @(posedge clk); #1; n++;
    end
    chk("a_reach_700_1", 32'(n < 10000), 32'd1);
    chk("a_pre_rst_hs", 32'({ifa.hsync, ifa.vsync, ifa.video_on}), 32'b010);
    #2 rst_a = 1'b1;
    #1;
    chk("a_async_rst", 32'({ifa.hsync, ifa.vsync, ifa.video_on, ifa.pix_tick, ifa.frame_start,
                            ifa.pixel_x, ifa.pixel_y}), 32'({5'b11000, 20'd0}));
    chk("a_no_frame_start", 32'(a_fs), 32'd0);

    chk("a_hs_low", 32'(a_rise[0] - a_fall[0]), 32'd384);
    chk("a_line_period", 32'(a_fall[1] - a_fall[0]), 32'd3200);
    chk("a_vid_per_line", 32'(a_vcum[1] - a_vcum[0]), 32'd2560);
    chk("b_hs_low", 32'(b_rise[0] - b_fall[0]), 32'd192);
    chk("b_line_period", 32'(b_fall[1] - b_fall[0]), 32'd1600);

    // Async reset of the tiny raster inside both sync pulses.
    @(posedge clk); #1;
    n = 0;
    while (!(ifs.pixel_x == 10'd11 && ifs.pixel_y == 10'd9) && n < 1000) begin
      @(posedge clk); #1; n++;
    end
    chk("s_reach_11_9", 32'(n < 1000), 32'd1);
    chk("s_pre_rst_syncs", 32'({ifs.hsync, ifs.vsync, ifs.video_on}), 32'b000);
    #2 rst_s = 1'b1;
    #1;
    chk("s_async_rst", 32'({ifs.hsync, ifs.vsync, ifs.video_on, ifs.pix_tick, ifs.frame_start,
                            ifs.pixel_x, ifs.pixel_y}), 32'({5'b11000, 20'd0}));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
